// File: rtl/dc_video_source.sv
// Dreamcast-style 12-bit multiplexed RGB video generator with active-low syncs.
// Two bus clocks per pixel; all outputs registered one clock behind the position counters.
module dc_video_source #(
    parameter int H_TOTAL      = 858,
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 700,
    parameter int H_SYNC_WIDTH = 62,
    parameter int V_TOTAL      = 525,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_WIDTH = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern,
    input  logic [23:0] fixed_rgb,
    output logic [11:0] data,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        phase,
    output logic [11:0] counterX,
    output logic [11:0] counterY,
    output logic        frame_start
);

    localparam logic [12:0] H_ACT_13 = 13'(H_ACTIVE);
    localparam logic [12:0] V_ACT_13 = 13'(V_ACTIVE);
    localparam logic [12:0] HS_LO_13 = 13'(H_SYNC_START);
    localparam logic [12:0] HS_HI_13 = 13'(H_SYNC_START + H_SYNC_WIDTH);
    localparam logic [12:0] VS_LO_13 = 13'(V_SYNC_START);
    localparam logic [12:0] VS_HI_13 = 13'(V_SYNC_START + V_SYNC_WIDTH);
    localparam logic [11:0] PX_LAST  = 12'(H_TOTAL - 1);
    localparam logic [11:0] PY_LAST  = 12'(V_TOTAL - 1);

    logic [11:0] px_r;
    logic [11:0] py_r;
    logic        ph_r;
    logic [1:0]  pat_r;
    logic [23:0] rgb_r;

    logic        at_origin_s;
    logic [1:0]  pat_s;
    logic [23:0] rgb_s;
    logic        active_s;
    logic [23:0] pixel_s;
    logic [11:0] data_s;
    logic        hsync_n_s;
    logic        vsync_n_s;

    // Pattern generator for one active pixel; bar colour bits are the inverted bar index bits.
    function automatic logic [23:0] pixel_f(input logic [1:0] pat, input logic [23:0] rgb,
                                            input logic [9:0] x, input logic [3:0] y);
        logic [2:0]  bar;
        logic [23:0] pix;
        bar = 3'(x / 10'd80);
        pix = 24'h000000;
        case (pat)
            2'd0: pix = rgb;
            2'd1: pix = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
            2'd2: pix = {x[7:0], x[7:0], x[7:0]};
            2'd3: pix = ((x[3:0] == 4'd0) || (y == 4'd0)) ? 24'hFFFFFF : 24'h000000;
            default: pix = 24'h000000;
        endcase
        return pix;
    endfunction

    // Pixel, multiplex and sync decode for the current position; new config applies from (0,0) itself.
    always_comb begin
        at_origin_s = (px_r == 12'd0) && (py_r == 12'd0) && !ph_r;
        pat_s       = at_origin_s ? pattern : pat_r;
        rgb_s       = at_origin_s ? fixed_rgb : rgb_r;
        active_s    = ({1'b0, px_r} < H_ACT_13) && ({1'b0, py_r} < V_ACT_13);
        if (active_s) begin
            pixel_s = pixel_f(pat_s, rgb_s, px_r[9:0], py_r[3:0]);
        end else begin
            pixel_s = 24'h000000;
        end
        data_s    = ph_r ? pixel_s[11:0] : pixel_s[23:12];
        hsync_n_s = !(({1'b0, px_r} >= HS_LO_13) && ({1'b0, px_r} < HS_HI_13));
        vsync_n_s = !(({1'b0, py_r} >= VS_LO_13) && ({1'b0, py_r} < VS_HI_13));
    end

    // Position counters: half-pixel phase, then pixel, then line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            px_r <= 12'd0;
            py_r <= 12'd0;
            ph_r <= 1'b0;
        end else if (enable) begin
            ph_r <= ~ph_r;
            if (ph_r) begin
                if (px_r == PX_LAST) begin
                    px_r <= 12'd0;
                    py_r <= (py_r == PY_LAST) ? 12'd0 : py_r + 12'd1;
                end else begin
                    px_r <= px_r + 12'd1;
                end
            end
        end
    end

    // Shadow configuration, refreshed only at the top of a frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pat_r <= 2'd0;
            rgb_r <= 24'h000000;
        end else if (enable && at_origin_s) begin
            pat_r <= pattern;
            rgb_r <= fixed_rgb;
        end
    end

    // Output registers; frame_start stays a single-clock pulse even across a freeze.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data        <= 12'h000;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            phase       <= 1'b0;
            counterX    <= 12'd0;
            counterY    <= 12'd0;
            frame_start <= 1'b0;
        end else if (enable) begin
            data        <= data_s;
            hsync_n     <= hsync_n_s;
            vsync_n     <= vsync_n_s;
            phase       <= ph_r;
            counterX    <= px_r;
            counterY    <= py_r;
            frame_start <= at_origin_s;
        end else begin
            frame_start <= 1'b0;
        end
    end

endmodule

// File: doc/dc_video_source.md
# dc_video_source

Synthesizable Dreamcast-style digital video bus generator: produces the 12-bit, two-clocks-per-pixel multiplexed RGB stream plus active-low syncs that the capture front end (data capture → `video2ram`) consumes. It is the transmitter end of that input interface. It drives the capture path in simulation and in on-board self-test builds, with selectable test patterns and reference pixel counters for scoreboarding against `wraddr`/`wrdata`.

## Interface
Parameters:
- H_TOTAL, 858: pixels per line.
- H_ACTIVE, 640: active pixels, x in [0, H_ACTIVE).
- H_SYNC_START, 700: first pixel of hsync.
- H_SYNC_WIDTH, 62: hsync length in pixels.
- V_TOTAL, 525: lines per frame.
- V_ACTIVE, 480: active lines, y in [0, V_ACTIVE).
- V_SYNC_START, 490: first line of vsync.
- V_SYNC_WIDTH, 6: vsync length in lines.

Ports:
- clock  in  1  bus clock (54 MHz nominal); two clocks per pixel.
- reset  in  1  asynchronous, active-low.
- enable  in  1  1 = advance timing; 0 = freeze.
- pattern  in  2  pattern select; sampled at frame start.
- fixed_rgb  in  24  {R,G,B} for pattern 0; sampled at frame start.
- data  out  12  multiplexed pixel bus.
- hsync_n  out  1  active-low horizontal sync.
- vsync_n  out  1  active-low vertical sync.
- phase  out  1  0 = first half of pixel, 1 = second half.
- counterX  out  12  x of pixel currently on `data`.
- counterY  out  12  y of pixel currently on `data`.
- frame_start  out  1  one-clock pulse on phase 0 of pixel (0,0).

## Operation
- Internal position registers px, py (12 bit), ph (1 bit); reset to 0,0,0.
- Per enabled clock: ph toggles. On ph 1→0: px increments; px == H_TOTAL-1 wraps to 0 and increments py; py == V_TOTAL-1 wraps to 0.
- enable = 0: position and all outputs hold their values; resume exactly where frozen.
- Config latch: pattern and fixed_rgb are captured into shadow registers when the position is (0,0,ph=0) and enable = 1; a change mid-frame takes effect on the next frame only. Reset shadow: pattern 0, fixed_rgb 0.
- Pixel {R,G,B} for active area (px < H_ACTIVE and py < V_ACTIVE):
  - 0: fixed_rgb.
  - 1: colour bars, bar = px[9:0] / 80 (bars 0..7): white, yellow, cyan, green, magenta, red, blue, black; components 8'hFF/8'h00.
  - 2: ramp, R = G = B = px[7:0].
  - 3: grid, 24'hFFFFFF where px[3:0] == 0 or py[3:0] == 0, else 24'h000000.
- Outside active area pixel = 24'h000000.
- Multiplexing: ph 0 → data = {R[7:0], G[7:4]}; ph 1 → data = {G[3:0], B[7:0]}.
- hsync_n = 0 while H_SYNC_START ≤ px < H_SYNC_START + H_SYNC_WIDTH (both phases).
- vsync_n = 0 for the whole line while V_SYNC_START ≤ py < V_SYNC_START + V_SYNC_WIDTH.
- Sync/active arithmetic uses 13-bit compares so START+WIDTH never overflows.

## Timing
- All outputs registered, computed from the position registers, one-clock latency. `data`, syncs, `phase`, `counterX`, `counterY` and `frame_start` are mutually aligned.
- Reset values: data 0, hsync_n 1, vsync_n 1, phase 0, counterX 0, counterY 0, frame_start 0.
- First valid output: the clock after the first enabled clock following reset release. That output is pixel (0,0) ph 0, with frame_start = 1.
- Frame period: 2 × H_TOTAL × V_TOTAL enabled clocks (900,900 with defaults). Line period: 1716 clocks.
- frame_start is high for exactly one clock per frame. It is re-asserted after a freeze only if the freeze ended at (0,0,ph=0) not yet emitted.
- Reset asserted mid-frame: outputs return to their reset values immediately (asynchronous). Restart is at (0,0) with shadow config cleared.

## Test plan
- Reset release, enable = 1, pattern 1: first output data = 12'hFFF, frame_start = 1. At counterX = 80 (yellow): ph 0 data = 12'hFFF, ph 1 data = 12'hF00. Next frame_start exactly 900,900 clocks later.
- Sync geometry: hsync_n low for exactly 124 clocks per line, first low at counterX = 700. vsync_n low for 6 × 1716 clocks starting at counterY = 490. Syncs idle high at counterX = 640, counterY = 0.
- Pattern 2, at counterX = 300: ph 0 data = {8'd44, 4'h2}, ph 1 data = {4'hC, 8'd44}. At counterX = 700: data = 0.
- Change pattern 0 → 3 at counterY = 100 with fixed_rgb = 24'h123456: line 101 still emits ph 0 = 12'h123, ph 1 = 12'h456. Grid appears only after the next frame_start.
- enable low for 37 clocks mid-line: all outputs frozen. After re-enable, the counterX/phase sequence continues with no skipped or repeated half-pixel.
- Async reset pulse at counterY = 300: outputs go to reset values without a clock edge. Restart at (0,0) with pattern 0, fixed_rgb 0 → data 0.
- Loopback through data capture → video2ram with line_doubler = 0: every wren write matches the generated pattern at the corresponding counterX/counterY.
